// File: rtl/band_mixer.sv
// band_mixer: recombines eight 16-bit signed equalizer bands into one
// saturated 16-bit sample through a 4-stage pipelined adder tree.
// Per-band mute mask and output attenuation shift travel with each sample.
// A single global advance (!out_valid || out_ready) stalls the whole pipe.
// Optional feature macro: BAND_MIXER_CLIP_CNT_EN builds the clip counter;
// when undefined, clip_count reads 0 and clip_clr is ignored.
module band_mixer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sig_in_1,
  input  logic [15:0] sig_in_2,
  input  logic [15:0] sig_in_3,
  input  logic [15:0] sig_in_4,
  input  logic [15:0] sig_in_5,
  input  logic [15:0] sig_in_6,
  input  logic [15:0] sig_in_7,
  input  logic [15:0] sig_in_8,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  mute_mask,
  input  logic [1:0]  shift_sel,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        clip,
  input  logic        clip_clr,
  output logic [15:0] clip_count
);

  logic [7:0][15:0]  w_band;
  logic [7:0][15:0]  w_m;
  logic [3:0][16:0]  w_p1;
  logic              w_advance;
  logic signed [18:0] w_shifted;
  logic              w_ovf;
  logic [15:0]       w_sat;

  logic [3:0][16:0]  r_s1;
  logic [1:0][17:0]  r_s2;
  logic [18:0]       r_s3;
  logic [1:0]        r_sh1;
  logic [1:0]        r_sh2;
  logic [1:0]        r_sh3;
  logic              r_v1;
  logic              r_v2;
  logic              r_v3;
  logic [15:0]       r_out_data;
  logic              r_out_valid;
  logic              r_clip;

  assign w_band = {sig_in_8, sig_in_7, sig_in_6, sig_in_5,
                   sig_in_4, sig_in_3, sig_in_2, sig_in_1};

  // The whole pipe moves only when the output slot is empty or being taken.
  assign w_advance = !r_out_valid || out_ready;
  // Reset forces ready high so upstream never sees a stall while clearing.
  assign in_ready  = w_advance || !rst_n;

  // Mute masked bands and form the sign-extended pair sums for stage 1.
  always_comb begin
    w_m  = '0;
    w_p1 = '0;
    for (int k = 0; k < 8; k++) begin
      if (mute_mask[k]) begin
        w_m[k] = 16'h0000;
      end else begin
        w_m[k] = w_band[k];
      end
    end
    for (int k = 0; k < 4; k++) begin
      w_p1[k] = {w_m[2*k][15], w_m[2*k]} + {w_m[2*k+1][15], w_m[2*k+1]};
    end
  end

  // Attenuate (floor shift) and saturate the 19-bit total to 16 bits.
  assign w_shifted = $signed(r_s3) >>> r_sh3;

  // Overflow exists when the bits above the 16-bit sign are not all copies of it.
  always_comb begin
    w_ovf = 1'b0;
    w_sat = w_shifted[15:0];
    if (!((&w_shifted[18:15]) || !(|w_shifted[18:15]))) begin
      w_ovf = 1'b1;
      if (w_shifted[18]) begin
        w_sat = 16'h8000;
      end else begin
        w_sat = 16'h7FFF;
      end
    end else begin
      w_ovf = 1'b0;
      w_sat = w_shifted[15:0];
    end
  end

  // Pipeline registers: load together on advance, hold together on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_s3        <= 19'd0;
      r_sh1       <= 2'd0;
      r_sh2       <= 2'd0;
      r_sh3       <= 2'd0;
      r_v1        <= 1'b0;
      r_v2        <= 1'b0;
      r_v3        <= 1'b0;
      r_out_data  <= 16'h0000;
      r_out_valid <= 1'b0;
      r_clip      <= 1'b0;
    end else if (w_advance) begin
      r_s1        <= w_p1;
      r_sh1       <= shift_sel;
      r_v1        <= in_valid;
      r_s2[0]     <= {r_s1[0][16], r_s1[0]} + {r_s1[1][16], r_s1[1]};
      r_s2[1]     <= {r_s1[2][16], r_s1[2]} + {r_s1[3][16], r_s1[3]};
      r_sh2       <= r_sh1;
      r_v2        <= r_v1;
      r_s3        <= {r_s2[0][17], r_s2[0]} + {r_s2[1][17], r_s2[1]};
      r_sh3       <= r_sh2;
      r_v3        <= r_v2;
      r_out_data  <= w_sat;
      r_out_valid <= r_v3;
      r_clip      <= r_v3 && w_ovf;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign clip      = r_clip;

`ifdef BAND_MIXER_CLIP_CNT_EN
  logic [15:0] r_clip_count;

  // Count clipped beats as they load into the output register; clear wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_clip_count <= 16'h0000;
    end else if (clip_clr) begin
      r_clip_count <= 16'h0000;
    end else if (w_advance && r_v3 && w_ovf && (r_clip_count != 16'hFFFF)) begin
      r_clip_count <= r_clip_count + 16'h0001;
    end
  end

  assign clip_count = r_clip_count;
`else
  logic w_unused_clip_clr;
  assign w_unused_clip_clr = clip_clr;
  assign clip_count = 16'h0000;
`endif

endmodule

// File: tb/tb_band_mixer.sv
// Directed self-checking bench for band_mixer.
module tb_band_mixer;

`ifdef BAND_MIXER_CLIP_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] sig_in_1, sig_in_2, sig_in_3, sig_in_4;
  logic [15:0] sig_in_5, sig_in_6, sig_in_7, sig_in_8;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  mute_mask;
  logic [1:0]  shift_sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        clip;
  logic        clip_clr;
  logic [15:0] clip_count;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  band_mixer dut (
    .clk(clk), .rst_n(rst_n),
    .sig_in_1(sig_in_1), .sig_in_2(sig_in_2), .sig_in_3(sig_in_3), .sig_in_4(sig_in_4),
    .sig_in_5(sig_in_5), .sig_in_6(sig_in_6), .sig_in_7(sig_in_7), .sig_in_8(sig_in_8),
    .in_valid(in_valid), .in_ready(in_ready), .mute_mask(mute_mask), .shift_sel(shift_sel),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .clip(clip), .clip_clr(clip_clr), .clip_count(clip_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bands(input logic [15:0] v);
    sig_in_1 = v; sig_in_2 = v; sig_in_3 = v; sig_in_4 = v;
    sig_in_5 = v; sig_in_6 = v; sig_in_7 = v; sig_in_8 = v;
  endtask

  // Accept one sample at edge N and return just after edge N+3.
  task automatic beat(input logic [7:0] m, input logic [1:0] sh);
    mute_mask = m;
    shift_sel = sh;
    in_valid  = 1'b1;
    step();
    in_valid  = 1'b0;
    step();
    step();
    chk("early_valid", {15'd0, out_valid}, 16'd0);
    step();
  endtask

  initial begin
    int nxt_in;
    int nxt_out;
    logic acc;
    logic xfer;
    logic [15:0] held;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clip_clr = 1'b0;
    mute_mask = 8'h00; shift_sel = 2'd0; set_bands(16'h0000);
    step();
    chk("ready_in_reset", {15'd0, in_ready}, 16'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_count", clip_count, 16'h0000);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_ready", {15'd0, in_ready}, 16'd1);

    // 8 x 1000 = 8000
    set_bands(16'd1000);
    beat(8'h00, 2'd0);
    chk("sum1000_valid", {15'd0, out_valid}, 16'd1);
    chk("sum1000_data", out_data, 16'd8000);
    chk("sum1000_clip", {15'd0, clip}, 16'd0);

    // Mute band 1 only: 7 x 1000
    beat(8'h01, 2'd0);
    chk("mute1_data", out_data, 16'd7000);

    // 8 x 32767 saturates positive
    set_bands(16'h7FFF);
    beat(8'h00, 2'd0);
    chk("pos_sat_data", out_data, 16'h7FFF);
    chk("pos_sat_clip", {15'd0, clip}, 16'd1);
    chk("pos_sat_count", clip_count, CNT_EN ? 16'd1 : 16'd0);
    step();
    chk("bubble_valid", {15'd0, out_valid}, 16'd0);
    chk("bubble_clip", {15'd0, clip}, 16'd0);

    // 262136 >> 3 = 32767 exactly, no clip
    beat(8'h00, 2'd3);
    chk("shift3_data", out_data, 16'h7FFF);
    chk("shift3_clip", {15'd0, clip}, 16'd0);

    // 8 x -32768 >> 3 = -32768, no clip
    set_bands(16'h8000);
    beat(8'h00, 2'd3);
    chk("neg_shift3_data", out_data, 16'h8000);
    chk("neg_shift3_clip", {15'd0, clip}, 16'd0);

    // 8 x -32768 unshifted saturates negative
    beat(8'h00, 2'd0);
    chk("neg_sat_data", out_data, 16'h8000);
    chk("neg_sat_clip", {15'd0, clip}, 16'd1);
    chk("neg_sat_count", clip_count, CNT_EN ? 16'd2 : 16'd0);

    // -1 >>> 1 floors to -1
    set_bands(16'h0000);
    sig_in_1 = 16'hFFFF;
    beat(8'h00, 2'd1);
    chk("floor_data", out_data, 16'hFFFF);
    chk("floor_clip", {15'd0, clip}, 16'd0);

    // Streamed 1..10 with bands 5..8 muted, output stalled for 5 cycles
    step();
    mute_mask = 8'hF0;
    shift_sel = 2'd0;
    nxt_in  = 1;
    nxt_out = 1;
    held    = 16'h0000;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 5 && c < 10);
      in_valid  = (nxt_in <= 10);
      set_bands(16'(nxt_in));
      #1;
      if (c == 5) begin
        chk("stall_ready_drop", {15'd0, in_ready}, 16'd0);
        held = out_data;
      end
      if (c > 5 && c < 10) begin
        chk("stall_hold", out_data, held);
      end
      acc  = in_valid && in_ready;
      xfer = out_valid && out_ready;
      if (xfer) begin
        chk("stream_data", out_data, 16'(4 * nxt_out));
        nxt_out++;
      end
      step();
      if (acc) nxt_in++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", 16'(nxt_out - 1), 16'd10);

    // Reset mid-stream drops in-flight samples
    set_bands(16'd5);
    in_valid = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    chk("ready_mid_reset", {15'd0, in_ready}, 16'd1);
    step();
    chk("mid_reset_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_reset_count", clip_count, 16'h0000);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_reset_no_beat", {15'd0, out_valid}, 16'd0);
    end

    // Clip counter: one clip, then a clip coincident with clip_clr
    set_bands(16'h7FFF);
    mute_mask = 8'h00;
    beat(8'h00, 2'd0);
    chk("cnt_one", clip_count, CNT_EN ? 16'd1 : 16'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    clip_clr = 1'b1;
    step();
    clip_clr = 1'b0;
    chk("clr_vs_clip_flag", {15'd0, clip}, 16'd1);
    chk("clr_vs_clip_count", clip_count, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/band_mixer.md
# band_mixer

Recombines the eight per-band 16-bit signed outputs of the equalizer's amplifier stage into one 16-bit signed audio sample. It is the stage directly downstream of the equalizer. It has a per-band mute mask, a selectable output attenuation shift, saturation to 16 bits and a ready/valid output handshake. It is a 4-stage pipelined adder tree with a global stall.

## Interface
- No parameters; widths fixed.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- sig_in_1 … sig_in_8  in  16 each  signed two's-complement band samples
- in_valid  in  1  the eight band samples are valid this cycle
- in_ready  out  1  mixer can accept; transfer when in_valid && in_ready
- mute_mask  in  8  bit k-1 set forces band k to 0; sampled at acceptance
- shift_sel  in  2  output attenuation, arithmetic right shift 0..3; sampled at acceptance
- out_data  out  16  signed mixed sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
- clip  out  1  qualifies current out_data: 1 = saturated
- clip_clr  in  1  synchronous clear of clip_count
- clip_count  out  16  saturating count of clipped output beats

## Operation
- Datapath:
  - Stage 1: register four 17-bit pair sums of the masked inputs (1+2, 3+4, 5+6, 7+8).
  - Stage 2: two 18-bit sums.
  - Stage 3: one 19-bit sum.
  - Stage 4: arithmetic right shift by shift_sel, which rounds toward −∞.
  - Saturate to [−32768, 32767] and register into out_data, clip and out_valid.
- Sign-extend at every add. No overflow is possible before stage 4.
- shift_sel and a valid bit travel with each sample through stages 1–3.
- Global advance = !out_valid || out_ready. in_ready = advance, combinational.
- When advance = 0, all pipeline registers hold.
- Bubbles (in_valid = 0 while advancing) propagate as invalid slots; they are not compressed.
- clip_count:
  - Increments by 1 when a clipped beat is loaded into the stage-4 register.
  - Holds at 0xFFFF.
  - clip_clr has priority over the increment in the same cycle.

## Timing
- Reset (rst_n = 0 at an edge) clears the following to 0: all valid bits, out_valid, out_data, clip, clip_count, and all stage data.
  - in_ready = 1 during and after reset.
  - A mid-stream reset discards every in-flight sample. No output beat is emitted for them.
- Latency: a sample accepted at edge N appears on out_data with out_valid = 1 after edge N+3, provided out_ready stays 1.
- Throughput: 1 sample/cycle with no stall.
- out_data, clip and out_valid stay stable while out_valid && !out_ready.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required for full rate.
- A clip_count increment is visible the cycle after the clipped beat loads. A clear is visible the cycle after clip_clr.

## Configuration
- BAND_MIXER_CLIP_CNT_EN defined: clip_count counter and clip_clr logic are built as described.
- Macro undefined:
  - clip_count is tied to 16'h0000 and clip_clr is ignored.
  - The clip flag remains functional.

## Test plan
- Reset then idle: clip_count = 0, out_data = 0, out_valid = 0, in_ready = 1.
- All bands = 1000, mask = 0x00, shift = 0, out_ready = 1: out_data = 8000, clip = 0, out_valid exactly 3 edges after the acceptance edge.
- All bands = 32767, shift = 0: out_data = 32767, clip = 1, clip_count = 1. Same inputs with shift = 3: 262136 >> 3 = 32767, clip = 0.
- All bands = −32768, shift = 3: out_data = −32768, clip = 0. Band 1 = −1 with others 0, shift = 1: out_data = −1 (floor).
- Back-to-back stream 1..10 (all bands = i, mask = 0xF0 so result = 4i), out_ready held low for 5 cycles mid-stream:
  - in_ready drops in the same cycle as the stall.
  - Output sequence 4, 8, …, 40 arrives with no loss or duplication.
- Reset during the stream: in-flight samples are dropped and out_valid = 0 the next cycle. With the macro defined, clip_clr coincident with a clip produces clip_count = 0.
